mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, sitting directly downstream of the execute stage and upstream of writeback. Consumes the execute stage's ALU result, opcode and destination fields; performs LDW/STW through a request/acknowledge data-memory port; and passes all other instructions through with one-cycle latency. While a memory access is outstanding, it stalls the upstream pipeline and inserts bubbles downstream. A cycle-count timeout turns a lost acknowledge into a sticky error instead of a hang.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 48 ++++
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, opcode encodings and opcode helpers for the memory stage.
package mem_stage_pkg;

    localparam int REG_WIDTH = 16;
    localparam int OPC_WIDTH = 8;

    localparam logic [OPC_WIDTH-1:0] OP_ADD = 8'h01;
    localparam logic [OPC_WIDTH-1:0] OP_AND = 8'h02;
    localparam logic [OPC_WIDTH-1:0] OP_BR  = 8'h20;
    localparam logic [OPC_WIDTH-1:0] OP_JSR = 8'h28;
    localparam logic [OPC_WIDTH-1:0] OP_LDW = 8'h40;
    localparam logic [OPC_WIDTH-1:0] OP_STW = 8'h41;

    function automatic logic is_mem_op(input logic [OPC_WIDTH-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side and data-memory-side signals of the memory stage.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH   = REG_WIDTH,
    parameter int ADDR_WIDTH   = 16,
    parameter int OPCODE_WIDTH = OPC_WIDTH
);
    logic                    I_LOCK;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [DATA_WIDTH-1:0]   I_ALUOut;
    logic [3:0]              I_DestRegIdx;
    logic [DATA_WIDTH-1:0]   I_DestValue;
    logic                    I_FetchStall;
    logic                    I_DepStall;
    logic                    I_MemAck;
    logic [DATA_WIDTH-1:0]   I_MemRData;

    logic                    O_LOCK;
    logic [OPCODE_WIDTH-1:0] O_Opcode;
    logic [3:0]              O_DestRegIdx;
    logic [DATA_WIDTH-1:0]   O_ALUOut;
    logic [DATA_WIDTH-1:0]   O_DestValue;
    logic                    O_FetchStall;
    logic                    O_DepStall;
    logic                    O_MemReq;
    logic                    O_MemWe;
    logic [ADDR_WIDTH-1:0]   O_MemAddr;
    logic [DATA_WIDTH-1:0]   O_MemWData;
    logic                    O_MemStall;
    logic                    O_MemErr;

    modport slave (
        input  I_LOCK, I_Opcode, I_ALUOut, I_DestRegIdx, I_DestValue,
               I_FetchStall, I_DepStall, I_MemAck, I_MemRData,
        output O_LOCK, O_Opcode, O_DestRegIdx, O_ALUOut, O_DestValue,
               O_FetchStall, O_DepStall, O_MemReq, O_MemWe, O_MemAddr,
               O_MemWData, O_MemStall, O_MemErr
    );

    modport master (
        output I_LOCK, I_Opcode, I_ALUOut, I_DestRegIdx, I_DestValue,
               I_FetchStall, I_DepStall, I_MemAck, I_MemRData,
        input  O_LOCK, O_Opcode, O_DestRegIdx, O_ALUOut, O_DestValue,
               O_FetchStall, O_DepStall, O_MemReq, O_MemWe, O_MemAddr,
               O_MemWData, O_MemStall, O_MemErr
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Loadable up-counter with clear and enable; tc flags the terminal count.
module mem_timeout_ctr #(
    parameter int WIDTH    = 6,
    parameter int TERMINAL = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)       count_d = '0;
        else if (load) count_d = load_val;
        else if (en)   count_d = count_q + 1'b1;
    end

    always_ff @(negedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tc = (count_q == WIDTH'(TERMINAL));
endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU ops through, runs LDW/STW over a req/ack port with
// upstream stall, and converts a lost acknowledge into a sticky error.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = REG_WIDTH,
    parameter int ADDR_WIDTH     = 16,
    parameter int OPCODE_WIDTH   = OPC_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       I_CLOCK,
    input  logic       I_RESET,
    mem_stage_if.slave bus
);
    localparam int CTR_WIDTH = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e                  state_q, state_d;
    logic                    lock_q, lock_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [3:0]              dest_idx_q, dest_idx_d;
    logic [DATA_WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [DATA_WIDTH-1:0]   dest_value_q, dest_value_d;
    logic                    fetch_stall_q, fetch_stall_d;
    logic                    dep_stall_q, dep_stall_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_stall_q, mem_stall_d;
    logic                    mem_err_q, mem_err_d;
    logic                    ctr_clr, ctr_en, ctr_tc;

    mem_timeout_ctr #(
        .WIDTH    (CTR_WIDTH),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk      (I_CLOCK),
        .rst      (I_RESET),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .load     (1'b0),
        .load_val ('0),
        .tc       (ctr_tc)
    );

    always_comb begin
        state_d       = state_q;
        lock_d        = 1'b0;
        opcode_d      = opcode_q;
        dest_idx_d    = dest_idx_q;
        alu_out_d     = alu_out_q;
        dest_value_d  = dest_value_q;
        fetch_stall_d = bus.I_FetchStall;
        dep_stall_d   = bus.I_DepStall;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_stall_d   = mem_stall_q;
        mem_err_d     = mem_err_q;
        ctr_clr       = 1'b0;
        ctr_en        = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.I_LOCK && is_mem_op(bus.I_Opcode)) begin
                opcode_d    = bus.I_Opcode;
                dest_idx_d  = bus.I_DestRegIdx;
                mem_addr_d  = bus.I_ALUOut[ADDR_WIDTH-1:0];
                mem_wdata_d = bus.I_DestValue;
                mem_we_d    = (bus.I_Opcode == OP_STW);
                mem_req_d   = 1'b1;
                mem_stall_d = 1'b1;
                ctr_clr     = 1'b1;
                state_d     = ST_BUSY;
            end else if (bus.I_LOCK) begin
                lock_d       = 1'b1;
                opcode_d     = bus.I_Opcode;
                dest_idx_d   = bus.I_DestRegIdx;
                alu_out_d    = bus.I_ALUOut;
                dest_value_d = bus.I_DestValue;
            end
        end else begin
            // An ack on the terminal-count edge still completes normally.
            if (bus.I_MemAck) begin
                lock_d       = 1'b1;
                dest_value_d = mem_we_q ? mem_wdata_q : bus.I_MemRData;
                mem_req_d    = 1'b0;
                mem_stall_d  = 1'b0;
                state_d      = ST_IDLE;
            end else if (ctr_tc) begin
                lock_d       = 1'b1;
                dest_value_d = mem_we_q ? mem_wdata_q : '0;
                mem_err_d    = 1'b1;
                mem_req_d    = 1'b0;
                mem_stall_d  = 1'b0;
                state_d      = ST_IDLE;
            end else begin
                ctr_en = 1'b1;
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_q       <= ST_IDLE;
            lock_q        <= 1'b0;
            opcode_q      <= '0;
            dest_idx_q    <= '0;
            alu_out_q     <= '0;
            dest_value_q  <= '0;
            fetch_stall_q <= 1'b0;
            dep_stall_q   <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_stall_q   <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            opcode_q      <= opcode_d;
            dest_idx_q    <= dest_idx_d;
            alu_out_q     <= alu_out_d;
            dest_value_q  <= dest_value_d;
            fetch_stall_q <= fetch_stall_d;
            dep_stall_q   <= dep_stall_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_stall_q   <= mem_stall_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign bus.O_LOCK       = lock_q;
    assign bus.O_Opcode     = opcode_q;
    assign bus.O_DestRegIdx = dest_idx_q;
    assign bus.O_ALUOut     = alu_out_q;
    assign bus.O_DestValue  = dest_value_q;
    assign bus.O_FetchStall = fetch_stall_q;
    assign bus.O_DepStall   = dep_stall_q;
    assign bus.O_MemReq     = mem_req_q;
    assign bus.O_MemWe      = mem_we_q;
    assign bus.O_MemAddr    = mem_addr_q;
    assign bus.O_MemWData   = mem_wdata_q;
    assign bus.O_MemStall   = mem_stall_q;
    assign bus.O_MemErr     = mem_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic against an access-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int OW  = 8;
    localparam int TMO = 4;

    logic clock;
    logic reset;

    mem_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) bus ();

    mem_stage #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .OPCODE_WIDTH   (OW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .I_CLOCK (clock),
        .I_RESET (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    // Reference model: expected outputs plus the one outstanding access.
    logic          exp_lock, exp_fetch, exp_dep, exp_req, exp_we, exp_stall, exp_err;
    logic [OW-1:0] exp_opcode;
    logic [3:0]    exp_idx;
    logic [DW-1:0] exp_alu, exp_dv, exp_wdata;
    logic [AW-1:0] exp_addr;
    bit            m_pending;
    bit            m_is_store;
    int            m_age;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit lk, input logic [OW-1:0] op, input logic [DW-1:0] alu,
                                 input logic [3:0] idx, input logic [DW-1:0] val,
                                 input bit ack, input logic [DW-1:0] rdata);
        bus.I_LOCK       = lk;
        bus.I_Opcode     = op;
        bus.I_ALUOut     = alu;
        bus.I_DestRegIdx = idx;
        bus.I_DestValue  = val;
        bus.I_MemAck     = ack;
        bus.I_MemRData   = rdata;
        bus.I_FetchStall = 1'($urandom);
        bus.I_DepStall   = 1'($urandom);
        @(negedge clock);
        #1;
    endtask

    initial begin
        exp_lock = 0; exp_fetch = 0; exp_dep = 0; exp_req = 0; exp_we = 0; exp_stall = 0;
        exp_err = 0; exp_opcode = '0; exp_idx = '0; exp_alu = '0; exp_dv = '0;
        exp_wdata = '0; exp_addr = '0; m_pending = 0; m_is_store = 0; m_age = 0;
    end

    // A completed access is either acknowledged, or abandoned after TMO busy edges.
    always @(negedge clock) begin
        if (reset) begin
            exp_lock = 0; exp_fetch = 0; exp_dep = 0; exp_req = 0; exp_we = 0; exp_stall = 0;
            exp_err = 0; exp_opcode = '0; exp_idx = '0; exp_alu = '0; exp_dv = '0;
            exp_wdata = '0; exp_addr = '0; m_pending = 0; m_age = 0;
        end else begin
            exp_fetch = bus.I_FetchStall;
            exp_dep   = bus.I_DepStall;
            exp_lock  = 0;
            if (m_pending) begin
                m_age++;
                if (bus.I_MemAck || m_age == TMO) begin
                    exp_lock  = 1;
                    exp_req   = 0;
                    exp_stall = 0;
                    m_pending = 0;
                    if (m_is_store)        exp_dv = exp_wdata;
                    else if (bus.I_MemAck) exp_dv = bus.I_MemRData;
                    else                   exp_dv = '0;
                    if (!bus.I_MemAck) exp_err = 1;
                end
            end else if (bus.I_LOCK) begin
                if (bus.I_Opcode == OP_LDW || bus.I_Opcode == OP_STW) begin
                    m_pending  = 1;
                    m_age      = 0;
                    m_is_store = (bus.I_Opcode == OP_STW);
                    exp_opcode = bus.I_Opcode;
                    exp_idx    = bus.I_DestRegIdx;
                    exp_addr   = bus.I_ALUOut[AW-1:0];
                    exp_wdata  = bus.I_DestValue;
                    exp_we     = m_is_store;
                    exp_req    = 1;
                    exp_stall  = 1;
                end else begin
                    exp_lock   = 1;
                    exp_opcode = bus.I_Opcode;
                    exp_idx    = bus.I_DestRegIdx;
                    exp_alu    = bus.I_ALUOut;
                    exp_dv     = bus.I_DestValue;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (checking) begin
            checkOutput("O_LOCK",       32'(bus.O_LOCK),       32'(exp_lock));
            checkOutput("O_Opcode",     32'(bus.O_Opcode),     32'(exp_opcode));
            checkOutput("O_DestRegIdx", 32'(bus.O_DestRegIdx), 32'(exp_idx));
            checkOutput("O_ALUOut",     32'(bus.O_ALUOut),     32'(exp_alu));
            checkOutput("O_DestValue",  32'(bus.O_DestValue),  32'(exp_dv));
            checkOutput("O_FetchStall", 32'(bus.O_FetchStall), 32'(exp_fetch));
            checkOutput("O_DepStall",   32'(bus.O_DepStall),   32'(exp_dep));
            checkOutput("O_MemReq",     32'(bus.O_MemReq),     32'(exp_req));
            checkOutput("O_MemWe",      32'(bus.O_MemWe),      32'(exp_we));
            checkOutput("O_MemAddr",    32'(bus.O_MemAddr),    32'(exp_addr));
            checkOutput("O_MemWData",   32'(bus.O_MemWData),   32'(exp_wdata));
            checkOutput("O_MemStall",   32'(bus.O_MemStall),   32'(exp_stall));
            checkOutput("O_MemErr",     32'(bus.O_MemErr),     32'(exp_err));
        end
    end

    initial begin
        int       busySeen;
        int       ackDelay;
        bit       ack;
        logic [OW-1:0] op;

        busySeen = 0;
        ackDelay = 0;
        reset = 1'b1;
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checking = 1'b1;
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("rst_lock",  32'(bus.O_LOCK),      32'h0);
        checkOutput("rst_opc",   32'(bus.O_Opcode),    32'h0);
        checkOutput("rst_dv",    32'(bus.O_DestValue), 32'h0);
        checkOutput("rst_alu",   32'(bus.O_ALUOut),    32'h0);
        checkOutput("rst_req",   32'(bus.O_MemReq),    32'h0);
        checkOutput("rst_addr",  32'(bus.O_MemAddr),   32'h0);
        checkOutput("rst_stall", 32'(bus.O_MemStall),  32'h0);
        checkOutput("rst_err",   32'(bus.O_MemErr),    32'h0);
        reset = 1'b0;

        $display("[TB] ADD pass-through");
        applyStimulus(1, OP_ADD, 16'h0005, 4'd3, 16'h0042, 0, '0);
        checkOutput("add_lock", 32'(bus.O_LOCK),       32'h1);
        checkOutput("add_idx",  32'(bus.O_DestRegIdx), 32'h3);
        checkOutput("add_dv",   32'(bus.O_DestValue),  32'h0042);
        checkOutput("add_req",  32'(bus.O_MemReq),     32'h0);
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("add_lock_drop", 32'(bus.O_LOCK), 32'h0);

        $display("[TB] LDW with delayed ack");
        applyStimulus(1, OP_LDW, 16'h0010, 4'd5, 16'h5555, 0, '0);
        checkOutput("ldw_req",   32'(bus.O_MemReq),   32'h1);
        checkOutput("ldw_stall", 32'(bus.O_MemStall), 32'h1);
        checkOutput("ldw_addr",  32'(bus.O_MemAddr),  32'h0010);
        checkOutput("ldw_we",    32'(bus.O_MemWe),    32'h0);
        checkOutput("ldw_lock0", 32'(bus.O_LOCK),     32'h0);
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("ldw_stall2", 32'(bus.O_MemStall), 32'h1);
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("ldw_stall3", 32'(bus.O_MemStall), 32'h1);
        applyStimulus(0, OP_ADD, '0, '0, '0, 1, 16'hBEEF);
        checkOutput("ldw_lock",  32'(bus.O_LOCK),      32'h1);
        checkOutput("ldw_dv",    32'(bus.O_DestValue), 32'hBEEF);
        checkOutput("ldw_idx",   32'(bus.O_DestRegIdx), 32'h5);
        checkOutput("ldw_done",  32'(bus.O_MemStall),  32'h0);

        $display("[TB] STW with immediate ack");
        applyStimulus(1, OP_STW, 16'h0020, 4'd2, 16'h1234, 0, '0);
        checkOutput("stw_we",    32'(bus.O_MemWe),    32'h1);
        checkOutput("stw_wdata", 32'(bus.O_MemWData), 32'h1234);
        checkOutput("stw_addr",  32'(bus.O_MemAddr),  32'h0020);
        applyStimulus(0, OP_ADD, '0, '0, '0, 1, 16'hDEAD);
        checkOutput("stw_lock",  32'(bus.O_LOCK),      32'h1);
        checkOutput("stw_dv",    32'(bus.O_DestValue), 32'h1234);
        checkOutput("stw_req",   32'(bus.O_MemReq),    32'h0);

        $display("[TB] timeout");
        applyStimulus(1, OP_LDW, 16'h0030, 4'd7, 16'h9999, 0, '0);
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
            checkOutput("tmo_wait_req", 32'(bus.O_MemReq), 32'h1);
            checkOutput("tmo_wait_err", 32'(bus.O_MemErr), 32'h0);
        end
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("tmo_err",   32'(bus.O_MemErr),    32'h1);
        checkOutput("tmo_lock",  32'(bus.O_LOCK),      32'h1);
        checkOutput("tmo_dv",    32'(bus.O_DestValue), 32'h0);
        checkOutput("tmo_stall", 32'(bus.O_MemStall),  32'h0);
        applyStimulus(1, OP_ADD, 16'h0001, 4'd1, 16'h0077, 0, '0);
        checkOutput("tmo_add_lock", 32'(bus.O_LOCK),      32'h1);
        checkOutput("tmo_add_dv",   32'(bus.O_DestValue), 32'h0077);
        checkOutput("tmo_sticky",   32'(bus.O_MemErr),    32'h1);

        $display("[TB] reset mid-access");
        applyStimulus(1, OP_LDW, 16'h0040, 4'd8, '0, 0, '0);
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        checkOutput("rma_busy", 32'(bus.O_MemReq), 32'h1);
        reset = 1'b1;
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);
        reset = 1'b0;
        checkOutput("rma_req",   32'(bus.O_MemReq),   32'h0);
        checkOutput("rma_stall", 32'(bus.O_MemStall), 32'h0);
        checkOutput("rma_lock",  32'(bus.O_LOCK),     32'h0);
        checkOutput("rma_err",   32'(bus.O_MemErr),   32'h0);
        applyStimulus(0, OP_ADD, '0, '0, '0, 1, 16'hAAAA);
        checkOutput("rma_late_lock", 32'(bus.O_LOCK),   32'h0);
        checkOutput("rma_late_req",  32'(bus.O_MemReq), 32'h0);

        $display("[TB] back-to-back LDW");
        applyStimulus(1, OP_LDW, 16'h0050, 4'd4, '0, 0, '0);
        applyStimulus(1, OP_LDW, 16'h0051, 4'd6, '0, 1, 16'h1111);
        checkOutput("b2b_lock1", 32'(bus.O_LOCK),      32'h1);
        checkOutput("b2b_dv1",   32'(bus.O_DestValue), 32'h1111);
        checkOutput("b2b_gap",   32'(bus.O_MemReq),    32'h0);
        applyStimulus(1, OP_LDW, 16'h0051, 4'd6, '0, 0, '0);
        checkOutput("b2b_req2",  32'(bus.O_MemReq),  32'h1);
        checkOutput("b2b_addr2", 32'(bus.O_MemAddr), 32'h0051);
        checkOutput("b2b_nolock", 32'(bus.O_LOCK),   32'h0);
        applyStimulus(0, OP_ADD, '0, '0, '0, 1, 16'h2222);
        checkOutput("b2b_lock2", 32'(bus.O_LOCK),       32'h1);
        checkOutput("b2b_dv2",   32'(bus.O_DestValue),  32'h2222);
        checkOutput("b2b_idx2",  32'(bus.O_DestRegIdx), 32'h6);
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (bus.O_MemReq) begin
                if (busySeen == 0) ackDelay = $urandom_range(1, TMO + 1);
                busySeen++;
                ack = (busySeen == ackDelay);
            end else begin
                busySeen = 0;
                ack = ($urandom_range(0, 7) == 0);
            end
            case ($urandom_range(0, 7))
                0:       op = OP_ADD;
                1:       op = OP_AND;
                2:       op = OP_BR;
                3:       op = OP_JSR;
                4, 5:    op = OP_LDW;
                6:       op = OP_STW;
                default: op = OW'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 3) != 0), op, DW'($urandom), 4'($urandom),
                          DW'($urandom), ack, DW'($urandom));
        end
        reset = 1'b0;
        applyStimulus(0, OP_ADD, '0, '0, '0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
